// File: rtl/sm_dmem_pkg.sv
// ============================================================================
// Module   : sm_dmem_pkg
// Brief    : Shared types and constants for the sm_dmem data-memory controller.
//            SM_DMEM_RANDOM_WAIT_EN widens the wait counter to 5 bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sm_dmem_pkg;

    typedef enum logic {
        DMEM_IDLE = 1'b0,
        DMEM_BUSY = 1'b1
    } dmem_state_t;

`ifdef SM_DMEM_RANDOM_WAIT_EN
    localparam int DMEM_CNT_W = 5;
`else
    localparam int DMEM_CNT_W = 4;
`endif

    localparam logic [7:0] DMEM_LFSR_SEED = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/sm_dmem_ram.sv
// ============================================================================
// Module   : sm_dmem_ram
// Brief    : Single-port synchronous 32-bit RAM with registered read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_dmem_ram #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wd,
    output logic [31:0]           rd
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wd;
        end
    end

    // Read register only updates on read accesses so data is held between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd <= 32'd0;
        end else if (en && !we) begin
            rd <= mem[addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sm_dmem_ctrl.sv
// ============================================================================
// Module   : sm_dmem_ctrl
// Brief    : Data-memory controller with programmable wait states in front of
//            an embedded RAM. SM_DMEM_RANDOM_WAIT_EN adds 0..3 LFSR wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_dmem_ctrl
    import sm_dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmAddr,
    input  logic        dmWe,
    input  logic [31:0] dmWData,
    input  logic        dmValid,
    output logic        dmReady,
    output logic [31:0] dmRData
);

    dmem_state_t           state, state_nx;
    logic [DMEM_CNT_W-1:0] cnt, cnt_nx, cnt_load;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic [31:0]           req_wdata;
    logic                  accept;
    logic                  access;
    logic                  ram_en;

    wire unused_addr_bits = ^{dmAddr[31:ADDR_WIDTH+2], dmAddr[1:0]};

`ifdef SM_DMEM_RANDOM_WAIT_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= DMEM_LFSR_SEED;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign cnt_load = DMEM_CNT_W'(WAIT_CYCLES - 1) + DMEM_CNT_W'(lfsr[1:0]);
`else
    assign cnt_load = DMEM_CNT_W'(WAIT_CYCLES - 1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DMEM_IDLE;
            cnt       <= '0;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                req_addr  <= dmAddr[ADDR_WIDTH+1:2];
                req_we    <= dmWe;
                req_wdata <= dmWData;
            end
        end
    end

    // dmValid while BUSY is a protocol violation and is deliberately ignored.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        access   = 1'b0;
        case (state)
            DMEM_IDLE: begin
                if (dmValid) begin
                    accept   = 1'b1;
                    cnt_nx   = cnt_load;
                    state_nx = DMEM_BUSY;
                end
            end
            DMEM_BUSY: begin
                if (cnt == '0) begin
                    access   = 1'b1;
                    state_nx = DMEM_IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = DMEM_IDLE;
        endcase
    end

    // Gate with rst so a reset coinciding with the final edge cannot write RAM.
    assign ram_en  = access & ~rst;
    assign dmReady = (state == DMEM_IDLE);

    sm_dmem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .en   (ram_en),
        .we   (req_we),
        .addr (req_addr),
        .wd   (req_wdata),
        .rd   (dmRData)
    );

endmodule

`default_nettype wire

// File: tb/tb_sm_dmem_ctrl.sv
// ============================================================================
// Module   : tb_sm_dmem_ctrl
// Brief    : Directed, table-driven self-checking bench for sm_dmem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm_dmem_ctrl;

    localparam int ADDR_WIDTH  = 6;
    localparam int WAIT_CYCLES = 2;
`ifdef SM_DMEM_RANDOM_WAIT_EN
    localparam int LAT_MIN = WAIT_CYCLES;
    localparam int LAT_MAX = WAIT_CYCLES + 3;
`else
    localparam int LAT_MIN = WAIT_CYCLES;
    localparam int LAT_MAX = WAIT_CYCLES;
`endif
    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dmAddr = 32'd0;
    logic        dmWe = 1'b0;
    logic [31:0] dmWData = 32'd0;
    logic        dmValid = 1'b0;
    logic        dmReady;
    logic [31:0] dmRData;

    int tests = 0;
    int fails = 0;

    sm_dmem_ctrl #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .dmAddr  (dmAddr),
        .dmWe    (dmWe),
        .dmWData (dmWData),
        .dmValid (dmValid),
        .dmReady (dmReady),
        .dmRData (dmRData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        imm;   // issue in the ready-rise cycle itself
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_lat(input string name, input int lc);
        tests++;
        if (lc < LAT_MIN || lc > LAT_MAX) begin
            fails++;
            $display("FAIL %s: low cycles %0d expected %0d..%0d", name, lc, LAT_MIN, LAT_MAX);
        end
    endtask

    // Starts and ends at a negedge; on return we sit in the ready-rise cycle.
    task automatic access(input logic we, input logic imm, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lowcnt);
        if (!imm) @(negedge clk);
        dmValid = 1'b1;
        dmWe    = we;
        dmAddr  = addr;
        dmWData = wdata;
        @(negedge clk);
        dmValid = 1'b0;
        dmWe    = 1'b0;
        lowcnt  = 0;
        while (!dmReady && lowcnt < TIMEOUT) begin
            lowcnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int lc;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0004, 32'h1122_3344, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0004, 32'h0000_0000, 32'h1122_3344};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h1122_3344};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0100, 32'hA5A5_A5A5, 32'h1122_3344};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_A5A5};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0003, 32'h0000_0000, 32'hA5A5_A5A5};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0808_0808, 32'hA5A5_A5A5};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'hA5A5_A5A5};

        // Reset and idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_ready", {31'd0, dmReady}, 32'd1);
            check("idle_rdata", dmRData, 32'd0);
        end

        // Table-driven accesses
        for (int i = 0; i < 10; i++) begin
            access(vecs[i].we, vecs[i].imm, vecs[i].addr, vecs[i].wdata, lc);
            check_lat($sformatf("vec%0d_lat", i), lc);
            check($sformatf("vec%0d_rdata", i), dmRData, vecs[i].exp_rd);
        end

        // Read data held across idle cycles after the writes
        repeat (3) @(negedge clk);
        check("hold_rdata", dmRData, 32'hA5A5_A5A5);

        // dmValid during BUSY: a write to 0x08 must be ignored
        access(1'b0, 1'b0, 32'h0000_0010, 32'd0, lc);
        check_lat("busy_read_lat", lc);
        check("busy_read_rdata", dmRData, 32'hDEAD_BEEF);
        @(negedge clk);
        dmValid = 1'b1; dmWe = 1'b0; dmAddr = 32'h0000_0010;
        @(negedge clk);
        dmValid = 1'b0;
        check("viol_busy", {31'd0, dmReady}, 32'd0);
        dmValid = 1'b1; dmWe = 1'b1; dmAddr = 32'h0000_0008; dmWData = 32'h0BAD_0BAD;
        @(negedge clk);
        dmValid = 1'b0; dmWe = 1'b0;
        lc = 1;
        while (!dmReady && lc < TIMEOUT) begin
            lc++;
            @(negedge clk);
        end
        check_lat("viol_lat", lc);
        repeat (WAIT_CYCLES + 4) @(negedge clk);
        check("viol_ready_after", {31'd0, dmReady}, 32'd1);
        access(1'b0, 1'b0, 32'h0000_0008, 32'd0, lc);
        check("viol_word08", dmRData, 32'h0808_0808);

        // Reset on the second BUSY cycle of a write to 0x20
        @(negedge clk);
        dmValid = 1'b1; dmWe = 1'b1; dmAddr = 32'h0000_0020; dmWData = 32'h1234_5678;
        @(negedge clk);
        dmValid = 1'b0; dmWe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_ready", {31'd0, dmReady}, 32'd1);
        check("rst_rdata", dmRData, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        access(1'b0, 1'b0, 32'h0000_0020, 32'd0, lc);
        check_lat("rst_read_lat", lc);
        check("rst_word20", dmRData, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sm_dmem_ctrl.md
Name: sm_dmem_ctrl

Overview:
- Data-memory controller sitting directly downstream of the CPU data-memory port (dmAddr/dmWe/dmWData/dmValid/dmReady/dmRData).
- Accepts one single-cycle request pulse, drops ready while the access is in flight, and performs a word access to an embedded synchronous RAM after a programmable number of wait states.
- Returns ready together with read data that the CPU writes back on the ready-rise cycle; emulates slow memory for stall/hazard exercising.

Parameters:
ADDR_WIDTH, 6, word-address width; RAM depth = 2**ADDR_WIDTH words of 32 bits
WAIT_CYCLES, 2, number of cycles ready is held low per access; legal range 1..15

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-high reset
dmAddr  input  32  byte address; bits [ADDR_WIDTH+1:2] select the word, all other bits ignored
dmWe  input  1  1 = write, 0 = read; sampled only with dmValid
dmWData  input  32  write data; sampled only with dmValid
dmValid  input  1  request strobe, one cycle wide
dmReady  output  1  1 = idle/done, 0 = access in flight
dmRData  output  32  read data; valid from the ready-rise cycle, held until the next read completes

Behaviour:
- Reset values: dmReady=1, dmRData=0, FSM=IDLE, wait counter=0, request registers=0. RAM contents are not reset.
- FSM states:
  - IDLE: dmReady=1.
    - On dmValid=1, latch the word address, dmWe and dmWData, load counter with WAIT_CYCLES-1, go to BUSY.
    - dmValid=0 means stay in IDLE.
  - BUSY: dmReady=0.
    - If counter!=0, decrement.
    - If counter==0, perform the access at this edge and go to IDLE.
    - Write: RAM[addr] <= wdata; dmRData unchanged.
    - Read: dmRData <= RAM[addr].
- Latency: request accepted at edge E0. dmReady=0 during cycles E0..E0+WAIT_CYCLES-1 (WAIT_CYCLES cycles). dmReady=1 and dmRData valid in the cycle after edge E0+WAIT_CYCLES.
- dmReady is a registered output: no combinational path from any input.
- dmValid while BUSY is a protocol violation. It is ignored: no new latch, no state change, the counter is unaffected.
- Back-to-back: a dmValid in the first IDLE cycle after completion is accepted. The CPU only issues one cycle later, and both cases must work.
- Read of a word written by the preceding access returns the new data (RAM write precedes the later read edge).
- Address wrap-around: upper address bits are dropped, so byte address 4*2**ADDR_WIDTH aliases word 0. Low two bits are ignored; there is no alignment fault.
- Counter width is 4 bits. WAIT_CYCLES=1 gives exactly one low cycle.
- Reset mid-operation (rst high in BUSY): return to IDLE with dmReady=1 and dmRData=0. The pending write is dropped, and no RAM word is modified at or after reset assertion.

Optional Feature:
SM_DMEM_RANDOM_WAIT_EN
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, reset seed 8'hA5) advances every accepted request.
  - The loaded counter becomes WAIT_CYCLES-1+lfsr[1:0], giving 0..3 extra low cycles.
  - The counter widens to 5 bits.
  - Used for stall-path stress in simulation.
- Undefined: fixed WAIT_CYCLES latency; no LFSR logic is present.

Decomposition:
- Shared package/header sm_dmem.vh:
  - state encodings DMEM_IDLE=1'b0, DMEM_BUSY=1'b1
  - counter width constant DMEM_CNT_W
  - LFSR seed constant DMEM_LFSR_SEED
- One sub-module, sm_dmem_ram: single-port synchronous 32-bit RAM with we, addr, wd, registered rd. Inferable as block RAM.
- The FSM, counter, request latches and LFSR stay in sm_dmem_ctrl.

Test Plan:
- Reset, then idle 5 cycles -> dmReady=1 and dmRData=0 throughout; no state change with dmValid=0.
- Write 32'hDEADBEEF to 0x10 (WAIT_CYCLES=2) -> dmReady low exactly 2 cycles then high. Read 0x10 -> dmRData=32'hDEADBEEF on the ready-rise cycle, held until the next read.
- Back-to-back: write 0x11223344 to 0x04, then read 0x04 issued on the first IDLE cycle, and again one cycle later -> both return 32'h11223344 with the correct low-time.
- Wrap: write 32'hA5A5A5A5 to 0x100 (ADDR_WIDTH=6), read 0x000 -> 32'hA5A5A5A5. Read 0x003 -> same word.
- Assert dmValid again during BUSY with a write to 0x08 -> ignored; word 0x08 unchanged and the original access completes on time.
- Assert rst on the second BUSY cycle of a write of 32'h12345678 to 0x20 -> dmReady=1, dmRData=0 immediately; a subsequent read of 0x20 returns the prior contents.
